stopwatch_bcd_counter: RTL

Timebase and BCD counting core of the stopwatch. Divides the board clock down to a 100 Hz tick and counts elapsed time as four BCD digits (SS.hh, 00.00–99.99) under start/stop and clear control. Its digit outputs feed the display scan stage, which selects one nibble at a time into the 0–9 seven-segment decoder. Every digit output is therefore always in the range 0–9.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_bcd_counter_digit.sv | 29 ++
 rtl/stopwatch_bcd_counter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase and BCD counting core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int   NUM_DIGITS = 4;
    localparam bcd_t BCD_MAX    = 4'd9;

endpackage

// File: rtl/stopwatch_bcd_counter_digit.sv
// One BCD decade (bcd_digit_counter): steps 0..9, carries out on the increment that wraps 9 -> 0.
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    bcd_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            // >= keeps the digit inside 0..9 even if it were ever disturbed
            r_q <= (r_q >= BCD_MAX) ? '0 : r_q + 4'd1;
        end
    end

    assign q     = r_q;
    assign carry = inc && (r_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: prescaler to a TICK_HZ tick, IDLE/RUN/PAUSE control, four chained BCD decades.
// Optional display freeze (lap) is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        tick,
    output logic        wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t                r_state;
    logic                  r_running;
    logic                  r_tick;
    logic                  r_wrap;
    logic [PW-1:0]         r_presc;
    logic                  w_inc;
    logic                  w_clr_cnt;
    logic [NUM_DIGITS:0]   w_carry;
    logic [15:0]           w_live;

    // clear wins over a coinciding increment edge
    assign w_inc     = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !clear;
    assign w_clr_cnt = clear || (r_state == ST_IDLE);
    assign w_carry[0] = w_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_tick <= w_inc;
            r_wrap <= w_carry[NUM_DIGITS];
            if (clear) begin
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
            end else if (start_stop) begin
                case (r_state)
                    ST_IDLE, ST_PAUSE: begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                    ST_RUN: begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Prescaler holds in PAUSE so a resume finishes the interrupted interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clear || (r_state == ST_IDLE)) begin
            r_presc <= '0;
        end else if (r_state == ST_RUN) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (w_clr_cnt),
            .inc   (w_carry[i]),
            .q     (w_live[4*i +: 4]),
            .carry (w_carry[i+1])
        );
    end

`ifdef STOPWATCH_LAP_EN
    logic [15:0] r_lap;
    logic        r_frozen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap    <= '0;
            r_frozen <= 1'b0;
        end else if (clear) begin
            r_frozen <= 1'b0;
        end else if (lap && (r_state != ST_IDLE)) begin
            if (r_frozen) begin
                r_frozen <= 1'b0;
            end else begin
                r_frozen <= 1'b1;
                r_lap    <= w_live;
            end
        end
    end

    assign digits = r_frozen ? r_lap : w_live;
`else
    assign digits = w_live;
`endif

    assign running = r_running;
    assign tick    = r_tick;
    assign wrap    = r_wrap;

endmodule
